adder_result_acc: RTL and testbench



---
 rtl/adder_result_acc.sv | 109 ++++++++++
 tb/tb_adder_result_acc.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/adder_result_acc.sv
// adder_result_acc
//   Sums COUNT consecutive 3-bit adder results {Co, S} into an ACC_W-bit
//   frame total. The total and a sticky overflow flag are presented through
//   a valid/ready handshake. After that handshake the block clears and
//   starts the next frame.
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   clr        synchronous clear, aborts the current frame (highest priority)
//   in_valid   an adder result is present on S/Co
//   in_ready   result can be accepted this cycle (low while a frame is held)
//   S, Co      adder sum bits and carry-out
//   out_valid  out_sum/out_ovf hold a completed frame
//   out_ready  consumer takes the frame this cycle
//   out_sum    frame total modulo 2^ACC_W
//   out_ovf    the running total exceeded 2^ACC_W-1 at some point in the frame
module adder_result_acc #(
  parameter int ACC_W = 8,
  parameter int COUNT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       S,
  input  logic             Co,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf
);

  localparam int CNT_W = $clog2(COUNT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic               ovf;
  logic [CNT_W-1:0]   cnt;

  logic [ACC_W:0]     sum_wide;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               accept;
  logic               last;

  // Zero-extended add; the top bit is the carry-out that feeds the sticky flag.
  function automatic logic [ACC_W:0] add_result(input logic [ACC_W-1:0] a,
                                                input logic [2:0]       v);
    return {1'b0, a} + {{(ACC_W - 2){1'b0}}, v};
  endfunction

  assign sum_wide = add_result(acc, {Co, S});
  assign cnt_nxt  = cnt + CNT_W'(1);
  assign accept   = in_valid && (state != HOLD);
  assign last     = (cnt_nxt == CNT_W'(COUNT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      ovf   <= 1'b0;
      cnt   <= '0;
    end else if (clr) begin
      state <= IDLE;
      acc   <= '0;
      ovf   <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE, ACC: begin
          if (accept) begin
            acc   <= sum_wide[ACC_W-1:0];
            ovf   <= ovf | sum_wide[ACC_W];
            cnt   <= cnt_nxt;
            state <= last ? HOLD : ACC;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state <= IDLE;
            acc   <= '0;
            ovf   <= 1'b0;
            cnt   <= '0;
          end
        end
        default: begin
          state <= IDLE;
          acc   <= '0;
          ovf   <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Outputs come only from registers and the state decode.
  assign in_ready  = (state != HOLD);
  assign out_valid = (state == HOLD);
  assign out_sum   = acc;
  assign out_ovf   = ovf;

endmodule

// File: tb/tb_adder_result_acc.sv
module tb_adder_result_acc;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic [1:0] S = 2'd0;
  logic       Co = 1'b0;
  logic       out_ready = 1'b0;

  logic       in_ready4, out_valid4, out_ovf4;
  logic [7:0] out_sum4;
  logic       in_ready64, out_valid64, out_ovf64;
  logic [7:0] out_sum64;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  adder_result_acc #(.ACC_W(8), .COUNT(4)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready4),
    .S(S), .Co(Co), .out_valid(out_valid4), .out_ready(out_ready),
    .out_sum(out_sum4), .out_ovf(out_ovf4)
  );

  adder_result_acc #(.ACC_W(8), .COUNT(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready64),
    .S(S), .Co(Co), .out_valid(out_valid64), .out_ready(out_ready),
    .out_sum(out_sum64), .out_ovf(out_ovf64)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: unbounded running total per frame, accept count, hold flag.
  int m_tot [2];
  int m_n   [2];
  bit m_hold[2];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n || clr) begin
        m_tot[i]  <= 0;
        m_n[i]    <= 0;
        m_hold[i] <= 1'b0;
      end else if (m_hold[i]) begin
        if (out_ready) begin
          m_tot[i]  <= 0;
          m_n[i]    <= 0;
          m_hold[i] <= 1'b0;
        end
      end else if (in_valid) begin
        m_tot[i]  <= m_tot[i] + int'({Co, S});
        m_n[i]    <= m_n[i] + 1;
        m_hold[i] <= ((m_n[i] + 1) == ((i == 0) ? 4 : 64));
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("m4_in_ready",   32'(in_ready4),   32'(!m_hold[0]));
    chk("m4_out_valid",  32'(out_valid4),  32'(m_hold[0]));
    chk("m4_out_sum",    32'(out_sum4),    32'(m_tot[0] % 256));
    chk("m4_out_ovf",    32'(out_ovf4),    32'(m_tot[0] > 255));
    chk("m64_in_ready",  32'(in_ready64),  32'(!m_hold[1]));
    chk("m64_out_valid", 32'(out_valid64), 32'(m_hold[1]));
    chk("m64_out_sum",   32'(out_sum64),   32'(m_tot[1] % 256));
    chk("m64_out_ovf",   32'(out_ovf64),   32'(m_tot[1] > 255));
  end

  // Drive one cycle of inputs, then return 1 time unit after the rising edge.
  task automatic step(input logic iv, input logic [2:0] val, input logic ordy, input logic c);
    in_valid  = iv;
    {Co, S}   = val;
    out_ready = ordy;
    clr       = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held: toggling in_valid must not accumulate.
    for (int k = 0; k < 4; k++) step(k[0], 3'd7, 1'b0, 1'b0);
    chk("rst_in_ready",  32'(in_ready4),  32'd1);
    chk("rst_out_valid", 32'(out_valid4), 32'd0);
    chk("rst_out_sum",   32'(out_sum4),   32'd0);
    chk("rst_out_ovf",   32'(out_ovf4),   32'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;

    // Basic frame: four accepts of 6.
    for (int k = 0; k < 3; k++) step(1'b1, 3'd6, 1'b0, 1'b0);
    chk("basic_not_yet_valid", 32'(out_valid4), 32'd0);
    step(1'b1, 3'd6, 1'b0, 1'b0);
    chk("basic_valid", 32'(out_valid4), 32'd1);
    chk("basic_sum",   32'(out_sum4),   32'd24);
    chk("basic_ovf",   32'(out_ovf4),   32'd0);
    chk("basic_ready_low", 32'(in_ready4), 32'd0);
    step(1'b0, 3'd0, 1'b1, 1'b0);
    chk("basic_ready_back", 32'(in_ready4),  32'd1);
    chk("basic_valid_drop", 32'(out_valid4), 32'd0);

    // Gaps and backpressure.
    for (int v = 1; v <= 4; v++) begin
      step(1'b1, 3'(v), 1'b0, 1'b0);
      if (v < 4) begin
        step(1'b0, 3'd0, 1'b0, 1'b0);
        step(1'b0, 3'd0, 1'b0, 1'b0);
      end
    end
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 3'd7, 1'b0, 1'b0);
      chk("bp_sum",      32'(out_sum4),   32'd10);
      chk("bp_valid",    32'(out_valid4), 32'd1);
      chk("bp_in_ready", 32'(in_ready4),  32'd0);
    end
    step(1'b0, 3'd0, 1'b1, 1'b0);
    chk("bp_done_valid", 32'(out_valid4), 32'd0);
    chk("bp_done_sum",   32'(out_sum4),   32'd0);

    // clr coincident with an accept discards it and the partial frame.
    step(1'b1, 3'd5, 1'b0, 1'b0);
    step(1'b1, 3'd5, 1'b0, 1'b0);
    chk("clr_partial", 32'(out_sum4), 32'd10);
    step(1'b1, 3'd5, 1'b0, 1'b1);
    chk("clr_cleared", 32'(out_sum4), 32'd0);
    for (int k = 0; k < 4; k++) step(1'b1, 3'd1, 1'b0, 1'b0);
    chk("clr_next_sum",   32'(out_sum4),   32'd4);
    chk("clr_next_valid", 32'(out_valid4), 32'd1);
    step(1'b0, 3'd0, 1'b1, 1'b1);
    chk("clr_hold_drop",  32'(out_valid4), 32'd0);
    chk("clr_hold_sum",   32'(out_sum4),   32'd0);

    // Overflow frame on the COUNT=64 instance: 64 x 6 = 384 -> 128, ovf set.
    for (int k = 0; k < 64; k++) step(1'b1, 3'd6, 1'b0, 1'b0);
    chk("ovf_valid", 32'(out_valid64), 32'd1);
    chk("ovf_sum",   32'(out_sum64),   32'd128);
    chk("ovf_flag",  32'(out_ovf64),   32'd1);
    step(1'b0, 3'd0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b1, 3'd1, 1'b0, 1'b0);
    chk("ovf_next_sum",  32'(out_sum64), 32'd4);
    chk("ovf_next_flag", 32'(out_ovf64), 32'd0);
    chk("ovf_next_m4",   32'(out_sum4),  32'd4);
    step(1'b0, 3'd0, 1'b1, 1'b1);

    // Asynchronous reset between edges after three accepts.
    for (int k = 0; k < 3; k++) step(1'b1, 3'd3, 1'b0, 1'b0);
    chk("arst_partial", 32'(out_sum4), 32'd9);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sum",       32'(out_sum4),   32'd0);
    chk("arst_in_ready",  32'(in_ready4),  32'd1);
    chk("arst_out_valid", 32'(out_valid4), 32'd0);
    chk("arst_ovf",       32'(out_ovf4),   32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) step(1'b1, 3'd2, 1'b0, 1'b0);
    chk("arst_next_sum",   32'(out_sum4),   32'd8);
    chk("arst_next_valid", 32'(out_valid4), 32'd1);
    step(1'b0, 3'd0, 1'b1, 1'b0);
    step(1'b0, 3'd0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
